// File: rtl/strap_capture_multi_if.sv
// Strap-capture bus: raw triggers/pins in, synchronised triggers and committed config out.
// The cfg_locked signal only exists when STRAP_CAPTURE_LOCK_EN is defined.
interface strap_capture_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       trig_n_in;
    logic [CHANNELS*WIDTH-1:0] pins_in;
    logic [CHANNELS-1:0]       trig_sync_n;
    logic [CHANNELS*WIDTH-1:0] cfg_out;
    logic [CHANNELS-1:0]       cfg_valid;
    logic [CHANNELS-1:0]       cfg_unstable;
    logic [CHANNELS-1:0]       cfg_update;
`ifdef STRAP_CAPTURE_LOCK_EN
    logic [CHANNELS-1:0]       cfg_locked;
`endif

    modport master (
        output trig_n_in, pins_in,
`ifdef STRAP_CAPTURE_LOCK_EN
        input  cfg_locked,
`endif
        input  trig_sync_n, cfg_out, cfg_valid, cfg_unstable, cfg_update
    );

    modport slave (
        input  trig_n_in, pins_in,
`ifdef STRAP_CAPTURE_LOCK_EN
        output cfg_locked,
`endif
        output trig_sync_n, cfg_out, cfg_valid, cfg_unstable, cfg_update
    );
endinterface

// File: rtl/strap_capture_multi.sv
// N-channel strap capture with stability check; STRAP_CAPTURE_LOCK_EN freezes a channel after its first commit.
// Latency: raw trigger rise to cfg_update = SYNC_STAGES+2 cycles; no backpressure, outputs are level/pulse.
module strap_capture_multi #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    strap_capture_multi_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Trigger chains reset to 0 so every channel opens a window straight out of reset.
    logic [SYNC_STAGES-1:0][CHANNELS-1:0]       trig_sync_q;
    logic [SYNC_STAGES-1:0][CHANNELS*WIDTH-1:0] pin_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_sync_q <= '0;
            pin_sync_q  <= '0;
        end else begin
            trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], bus.trig_n_in};
            pin_sync_q  <= {pin_sync_q[SYNC_STAGES-2:0], bus.pins_in};
        end
    end

    logic [CHANNELS-1:0]            trig_s;
    logic [CHANNELS-1:0][WIDTH-1:0] pin_s;
    assign trig_s = trig_sync_q[SYNC_STAGES-1];
    assign pin_s  = pin_sync_q[SYNC_STAGES-1];

    logic [CHANNELS-1:0][WIDTH-1:0] cfg_all;
    logic [CHANNELS-1:0]            valid_all;
    logic [CHANNELS-1:0]            unstable_all;
    logic [CHANNELS-1:0]            update_all;
`ifdef STRAP_CAPTURE_LOCK_EN
    logic [CHANNELS-1:0]            locked_all;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state_q;
        logic [CW-1:0]    cnt_q;
        logic [CW-1:0]    cnt_d;
        logic [WIDTH-1:0] sample_q;
        logic [WIDTH-1:0] cfg_q;
        logic             valid_q;
        logic             unstable_q;
        logic             update_q;
        logic             commit_ok;
        logic             gate_open;

        assign commit_ok = (cnt_q >= CNT_MAX);
        assign cnt_d     = commit_ok ? cnt_q : cnt_q + CNT_ONE;

`ifdef STRAP_CAPTURE_LOCK_EN
        logic locked_q;
        assign gate_open     = ~locked_q;
        assign locked_all[c] = locked_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                locked_q <= 1'b0;
            end else if (state_q == COMMIT && commit_ok) begin
                locked_q <= 1'b1;
            end
        end
`else
        assign gate_open = 1'b1;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                sample_q   <= '0;
                cfg_q      <= '0;
                valid_q    <= 1'b0;
                unstable_q <= 1'b0;
                update_q   <= 1'b0;
            end else begin
                update_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (!trig_s[c]) begin
                            state_q  <= ARMED;
                            sample_q <= pin_s[c];
                            cnt_q    <= CNT_ONE;
                        end
                    end
                    ARMED: begin
                        // The pin sample in the release cycle is deliberately dropped.
                        if (trig_s[c]) begin
                            state_q <= COMMIT;
                        end else if (pin_s[c] == sample_q) begin
                            cnt_q <= cnt_d;
                        end else begin
                            sample_q <= pin_s[c];
                            cnt_q    <= CNT_ONE;
                        end
                    end
                    COMMIT: begin
                        state_q <= IDLE;
                        if (gate_open) begin
                            if (commit_ok) begin
                                cfg_q      <= sample_q;
                                valid_q    <= 1'b1;
                                unstable_q <= 1'b0;
                                update_q   <= 1'b1;
                            end else begin
                                unstable_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign cfg_all[c]      = cfg_q;
        assign valid_all[c]    = valid_q;
        assign unstable_all[c] = unstable_q;
        assign update_all[c]   = update_q;
    end

    assign bus.trig_sync_n  = trig_s;
    assign bus.cfg_out      = cfg_all;
    assign bus.cfg_valid    = valid_all;
    assign bus.cfg_unstable = unstable_all;
    assign bus.cfg_update   = update_all;
`ifdef STRAP_CAPTURE_LOCK_EN
    assign bus.cfg_locked   = locked_all;
`endif
endmodule

// File: tb/tb_strap_capture_multi.sv
// Bench for strap_capture_multi: window-list reference model feeding a per-cycle scoreboard.
module tb_strap_capture_multi;
    localparam int W  = 8;
    localparam int C  = 4;
    localparam int ST = 4;
    localparam int S  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    strap_capture_multi_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    strap_capture_multi #(
        .WIDTH(W), .CHANNELS(C), .STABLE_CYCLES(ST), .SYNC_STAGES(S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [C-1:0]   tsync;
        logic [C*W-1:0] cfg;
        logic [C-1:0]   vld;
        logic [C-1:0]   unst;
        logic [C-1:0]   upd;
        logic [C-1:0]   lck;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: synchronisers are pure delay lines, a window is the list
    // of synced pin samples, and a commit is judged on the trailing run length.
    logic [C-1:0]   m_tq[$];
    logic [C*W-1:0] m_pq[$];
    int             m_phase[C];
    logic [W-1:0]   m_win[C][$];
    logic [W-1:0]   m_cfg[C];
    logic           m_vld[C];
    logic           m_unst[C];
    logic           m_upd[C];
    logic           m_lck[C];

    function automatic int trail_run(input int c);
        int n;
        logic [W-1:0] last;
        n = 0;
        last = m_win[c][m_win[c].size()-1];
        for (int i = m_win[c].size() - 1; i >= 0; i--) begin
            if (m_win[c][i] != last) break;
            n++;
        end
        return n;
    endfunction

    function automatic void model_reset();
        m_tq.delete();
        m_pq.delete();
        for (int i = 0; i < S; i++) begin
            m_tq.push_back('0);
            m_pq.push_back('0);
        end
        for (int c = 0; c < C; c++) begin
            m_phase[c] = 0;
            m_win[c].delete();
            m_cfg[c]  = '0;
            m_vld[c]  = 1'b0;
            m_unst[c] = 1'b0;
            m_upd[c]  = 1'b0;
            m_lck[c]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input logic r, input logic [C-1:0] t, input logic [C*W-1:0] p);
        logic [C-1:0]   s;
        logic [C*W-1:0] pv;
        logic [W-1:0]   ps;
        if (r) begin
            model_reset();
        end else begin
            s  = m_tq[m_tq.size()-1];
            pv = m_pq[m_pq.size()-1];
            for (int c = 0; c < C; c++) begin
                m_upd[c] = 1'b0;
                ps = pv[c*W +: W];
                case (m_phase[c])
                    0: if (!s[c]) begin
                        m_win[c].delete();
                        m_win[c].push_back(ps);
                        m_phase[c] = 1;
                    end
                    1: if (s[c]) m_phase[c] = 2;
                       else m_win[c].push_back(ps);
                    default: begin
                        m_phase[c] = 0;
                        if (!m_lck[c]) begin
                            if (trail_run(c) >= ST) begin
                                m_cfg[c]  = m_win[c][m_win[c].size()-1];
                                m_vld[c]  = 1'b1;
                                m_unst[c] = 1'b0;
                                m_upd[c]  = 1'b1;
`ifdef STRAP_CAPTURE_LOCK_EN
                                m_lck[c]  = 1'b1;
`endif
                            end else begin
                                m_unst[c] = 1'b1;
                            end
                        end
                    end
                endcase
            end
            m_tq.push_front(t);
            void'(m_tq.pop_back());
            m_pq.push_front(p);
            void'(m_pq.pop_back());
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.tsync = m_tq[m_tq.size()-1];
        for (int c = 0; c < C; c++) begin
            e.cfg[c*W +: W] = m_cfg[c];
            e.vld[c]  = m_vld[c];
            e.unst[c] = m_unst[c];
            e.upd[c]  = m_upd[c];
            e.lck[c]  = m_lck[c];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per driven cycle, compared just after the edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc++;
            chk("trig_sync_n",  64'(bus.trig_sync_n),  64'(mon_e.tsync));
            chk("cfg_out",      64'(bus.cfg_out),      64'(mon_e.cfg));
            chk("cfg_valid",    64'(bus.cfg_valid),    64'(mon_e.vld));
            chk("cfg_unstable", 64'(bus.cfg_unstable), 64'(mon_e.unst));
            chk("cfg_update",   64'(bus.cfg_update),   64'(mon_e.upd));
`ifdef STRAP_CAPTURE_LOCK_EN
            chk("cfg_locked",   64'(bus.cfg_locked),   64'(mon_e.lck));
`endif
        end
    end

    logic [C-1:0]   tr;
    logic [C*W-1:0] pv;

    task automatic drive(input logic r);
        @(negedge clk);
        rst           = r;
        bus.trig_n_in = tr;
        bus.pins_in   = pv;
        model_step(r, tr, pv);
        exp_q.push_back(snapshot());
    endtask

    task automatic run(input int n);
        repeat (n) drive(1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        tr            = '1;
        pv            = '0;
        bus.trig_n_in = tr;
        bus.pins_in   = pv;
        model_reset();

        do_reset(3);
        run(8);

        // Stable 0xA5 window on channel 0.
        pv[0*W +: W] = 8'hA5;
        tr[0] = 1'b0;
        run(10);
        tr[0] = 1'b1;
        run(8);

        // Toggling pins, last value stable only 2 cycles.
        do_reset(2);
        run(8);
        tr[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pv[0*W +: W] = (i % 2 == 1) ? 8'hC3 : 8'h3C;
            run(1);
        end
        run(1);
        tr[0] = 1'b1;
        run(8);

        // Two consecutive windows on channel 1.
        pv[1*W +: W] = 8'h11;
        tr[1] = 1'b0;
        run(8);
        tr[1] = 1'b1;
        run(6);
        pv[1*W +: W] = 8'h22;
        tr[1] = 1'b0;
        run(8);
        tr[1] = 1'b1;
        run(8);

        // Reset in the middle of an armed window on channel 2.
        pv[2*W +: W] = 8'hFF;
        tr[2] = 1'b0;
        run(S + 1 + 3);
        do_reset(2);
        run(8);
        tr[2] = 1'b1;
        run(8);

        // All channels released on the same raw edge.
        pv = 32'h0804_0201;
        tr = '0;
        run(8);
        tr = '1;
        run(8);

        // Re-trigger on channel 3 one cycle after release.
        pv[3*W +: W] = 8'h5A;
        tr[3] = 1'b0;
        run(8);
        tr[3] = 1'b1;
        run(1);
        tr[3] = 1'b0;
        pv[3*W +: W] = 8'h6B;
        run(8);
        tr[3] = 1'b1;
        run(8);

        // Randomised traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(0, 7) == 0) tr[c] = ~tr[c];
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 4))
                        0: pv[c*W +: W] = 8'h00;
                        1: pv[c*W +: W] = 8'h5A;
                        2: pv[c*W +: W] = 8'hA5;
                        3: pv[c*W +: W] = 8'hFF;
                        default: pv[c*W +: W] = 8'($urandom);
                    endcase
                end
            end
            drive($urandom_range(0, 149) == 0);
        end

        tr = '1;
        run(10);
        @(posedge clk);
        #3;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
